// File: rtl/reg_access_arbiter.sv
// Two-requester register-bank access arbiter: round-robin grant on ties,
// fixed three-cycle IDLE -> ACCESS -> RESP transaction with registered outputs.
module reg_access_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int REG_COUNT = 9
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             req_i,
    input  logic [1:0]             wr_i,
    input  logic [2*ADDR_SIZE-1:0] addr_i,
    input  logic [15:0]            wdata_i,
    output logic [1:0]             done_o,
    output logic                   err_o,
    output logic [7:0]             rdata_o,
    output logic                   busy_o,
    output logic                   acc_en_o,
    output logic                   wr_en_o,
    output logic [ADDR_SIZE-1:0]   addr_o,
    output logic [7:0]             wdata_o,
    input  logic [7:0]             rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [ADDR_SIZE:0] REG_LIMIT = (ADDR_SIZE + 1)'(REG_COUNT);

    state_t state_q;
    logic   last_grant_q;
    logic   win_q;
    logic   wr_q;
    logic   in_range_q;

    logic                 win_d;
    logic [ADDR_SIZE-1:0] win_addr_d;
    logic [7:0]           win_wdata_d;
    logic                 win_in_range_d;

    // Single requester wins outright; on a tie the one not granted last time wins.
    always_comb begin
        win_d = 1'b0;
        unique case (req_i)
            2'b01:   win_d = 1'b0;
            2'b10:   win_d = 1'b1;
            2'b11:   win_d = ~last_grant_q;
            default: win_d = 1'b0;
        endcase
        win_addr_d     = win_d ? addr_i[2*ADDR_SIZE-1:ADDR_SIZE] : addr_i[ADDR_SIZE-1:0];
        win_wdata_d    = win_d ? wdata_i[15:8] : wdata_i[7:0];
        win_in_range_d = ({1'b0, win_addr_d} < REG_LIMIT);
    end

    assign busy_o = (state_q != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            wr_q         <= 1'b0;
            in_range_q   <= 1'b0;
            acc_en_o     <= 1'b0;
            wr_en_o      <= 1'b0;
            addr_o       <= '0;
            wdata_o      <= '0;
            done_o       <= '0;
            err_o        <= 1'b0;
            rdata_o      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        state_q      <= ACCESS;
                        win_q        <= win_d;
                        last_grant_q <= win_d;
                        wr_q         <= wr_i[win_d];
                        in_range_q   <= win_in_range_d;
                        // Bank strobes are loaded here so they are live for the whole ACCESS cycle.
                        acc_en_o     <= win_in_range_d;
                        wr_en_o      <= win_in_range_d & wr_i[win_d];
                        addr_o       <= win_in_range_d ? win_addr_d : '0;
                        wdata_o      <= win_in_range_d ? win_wdata_d : '0;
                    end
                end
                ACCESS: begin
                    state_q  <= RESP;
                    acc_en_o <= 1'b0;
                    wr_en_o  <= 1'b0;
                    addr_o   <= '0;
                    wdata_o  <= '0;
                    done_o   <= win_q ? 2'b10 : 2'b01;
                    err_o    <= ~in_range_q;
                    rdata_o  <= (!wr_q && in_range_q) ? rdata_i : 8'h00;
                end
                RESP: begin
                    state_q <= IDLE;
                    done_o  <= '0;
                    err_o   <= 1'b0;
                    rdata_o <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
